// File: rtl/sym_vn_lut_rank_pkg.sv
// sym_vn_pkg: shared widths and types for the symmetric VN LUT datapath
package sym_vn_pkg;
  localparam int QUAN_SIZE  = 4;
  localparam int Y0_W       = 3;
  localparam int PAGE_W     = 6;
  localparam int BANK_DEPTH = 2 ** (PAGE_W + 1);
  typedef logic [QUAN_SIZE-1:0] msg_t;
  typedef logic [PAGE_W-1:0]    page_t;
endpackage

// File: rtl/sym_vn_lut_rank_if.sv
// sym_vn_lut_rank_if: dual read ports plus shared write port of the VN LUT
interface sym_vn_lut_rank_if;
  import sym_vn_pkg::*;
  logic [Y0_W-1:0] y0_in_A;
  msg_t            y1_in_A;
  logic [Y0_W-1:0] y0_in_B;
  msg_t            y1_in_B;
  logic            read_addr_offset;
  msg_t            lut_data0;
  msg_t            lut_data1;
  msg_t            lut_in_bank0;
  msg_t            lut_in_bank1;
  page_t           page_write_addr;
  logic            write_addr_offset;
  logic            we;
  modport master (
    output y0_in_A, y1_in_A, y0_in_B, y1_in_B, read_addr_offset,
    output lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we,
    input  lut_data0, lut_data1
  );
  modport slave (
    input  y0_in_A, y1_in_A, y0_in_B, y1_in_B, read_addr_offset,
    input  lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we,
    output lut_data0, lut_data1
  );
endinterface

// File: rtl/sym_vn_lut_rank_addr_map.sv
// vn_lut_addr_map: folds {y0, y1} into a page address and a bank select
module vn_lut_addr_map
  import sym_vn_pkg::*;
(
  input  logic [Y0_W-1:0] y0,
  input  msg_t            y1,
  output page_t           page_addr,
  output logic            bank_addr
);
  assign page_addr = {y0, y1[QUAN_SIZE-1:1]};
  assign bank_addr = y1[0];
endmodule

// File: rtl/sym_vn_lut_rank.sv
// sym_vn_lut_rank: dual-bank VN update table with two combinational read ports
module sym_vn_lut_rank
  import sym_vn_pkg::*;
(
  input logic              clk,
  input logic              rst,
  sym_vn_lut_rank_if.slave bus
);
  msg_t            bank0 [BANK_DEPTH];
  msg_t            bank1 [BANK_DEPTH];
  page_t           page_a;
  page_t           page_b;
  logic            bank_a;
  logic            bank_b;
  logic [PAGE_W:0] rd_a;
  logic [PAGE_W:0] rd_b;
  logic [PAGE_W:0] wr_idx;
  vn_lut_addr_map u_map_a (
    .y0        (bus.y0_in_A),
    .y1        (bus.y1_in_A),
    .page_addr (page_a),
    .bank_addr (bank_a)
  );
  vn_lut_addr_map u_map_b (
    .y0        (bus.y0_in_B),
    .y1        (bus.y1_in_B),
    .page_addr (page_b),
    .bank_addr (bank_b)
  );
  assign rd_a   = {bus.read_addr_offset, page_a};
  assign rd_b   = {bus.read_addr_offset, page_b};
  assign wr_idx = {bus.write_addr_offset, bus.page_write_addr};
  // Reset wins over a coincident write; both banks always load together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (bus.we) begin
      bank0[wr_idx] <= bus.lut_in_bank0;
      bank1[wr_idx] <= bus.lut_in_bank1;
    end
  end
  assign bus.lut_data0 = bank_a ? bank1[rd_a] : bank0[rd_a];
  assign bus.lut_data1 = bank_b ? bank1[rd_b] : bank0[rd_b];
endmodule

// File: tb/tb_sym_vn_lut_rank.sv
// tb_sym_vn_lut_rank: directed plus randomized checks against a table model
module tb_sym_vn_lut_rank;
  import sym_vn_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   m0 [128];
  int   m1 [128];
  always #5 clk = ~clk;
  sym_vn_lut_rank_if bus ();
  sym_vn_lut_rank dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic int model_rd(int off, int y0, int y1);
    int idx = off * 64 + y0 * 8 + y1 / 2;
    return (y1 % 2 == 1) ? m1[idx] : m0[idx];
  endfunction
  task automatic chk(string tag, logic [3:0] obs, int exp);
    logic [3:0] e = 4'(exp);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask
  task automatic wr(int off, int page, int d0, int d1);
    @(negedge clk);
    bus.we = 1'b1;
    bus.write_addr_offset = 1'(off);
    bus.page_write_addr = 6'(page);
    bus.lut_in_bank0 = 4'(d0);
    bus.lut_in_bank1 = 4'(d1);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    m0[off * 64 + page] = d0 % 16;
    m1[off * 64 + page] = d1 % 16;
  endtask
  task automatic rd(string tag, int off, int ya0, int ya1, int yb0, int yb1);
    bus.read_addr_offset = 1'(off);
    bus.y0_in_A = 3'(ya0);
    bus.y1_in_A = 4'(ya1);
    bus.y0_in_B = 3'(yb0);
    bus.y1_in_B = 4'(yb1);
    #1;
    chk({tag, "_A"}, bus.lut_data0, model_rd(off, ya0, ya1));
    chk({tag, "_B"}, bus.lut_data1, model_rd(off, yb0, yb1));
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.we = 1'b1;
    bus.write_addr_offset = 1'b0;
    bus.page_write_addr = 6'h2A;
    bus.lut_in_bank0 = 4'hF;
    bus.lut_in_bank1 = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.we = 1'b0;
    for (int i = 0; i < 128; i++) begin
      m0[i] = 0;
      m1[i] = 0;
    end
  endtask
  initial begin
    rst = 1'b0;
    bus.we = 1'b0;
    bus.read_addr_offset = 1'b0;
    bus.y0_in_A = '0;
    bus.y1_in_A = '0;
    bus.y0_in_B = '0;
    bus.y1_in_B = '0;
    bus.lut_in_bank0 = '0;
    bus.lut_in_bank1 = '0;
    bus.page_write_addr = '0;
    bus.write_addr_offset = 1'b0;
    do_reset();
    chk("reset_a", bus.lut_data0, 0);
    rd("reset", 0, 5, 4'b0100, 5, 4'b0101);
    wr(0, 6'h2A, 5, 4'hA);
    rd("wr_readback", 0, 5, 4'b0100, 5, 4'b0101);
    chk("wr_a_const", bus.lut_data0, 5);
    chk("wr_b_const", bus.lut_data1, 4'hA);
    wr(1, 6'h2A, 3, 4'hC);
    rd("off0", 0, 5, 4'b0100, 5, 4'b0101);
    rd("off1", 1, 5, 4'b0100, 5, 4'b0101);
    chk("off1_a_const", bus.lut_data0, 3);
    chk("off1_b_const", bus.lut_data1, 4'hC);
    rd("same_entry", 0, 5, 4'b0100, 5, 4'b0100);
    chk("same_entry_const", bus.lut_data1, 5);
    @(negedge clk);
    bus.read_addr_offset = 1'b0;
    bus.y0_in_A = 3'b101;
    bus.y1_in_A = 4'b0100;
    bus.we = 1'b1;
    bus.write_addr_offset = 1'b0;
    bus.page_write_addr = 6'h2A;
    bus.lut_in_bank0 = 4'h9;
    bus.lut_in_bank1 = 4'(m1[6'h2A]);
    #1;
    chk("collide_before", bus.lut_data0, 5);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    m0[6'h2A] = 9;
    chk("collide_after", bus.lut_data0, 9);
    for (int i = 0; i < 128; i++) wr(i / 64, i % 64, i % 16, (i * 7 + 3) % 16);
    for (int off = 0; off < 2; off++)
      for (int y0 = 0; y0 < 8; y0++)
        for (int y1 = 0; y1 < 16; y1++)
          rd("sweep", off, y0, y1, 7 - y0, 15 - y1);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0)
        wr($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 15));
      rd("rand", $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15),
         $urandom_range(0, 7), $urandom_range(0, 15));
    end
    do_reset();
    for (int n = 0; n < 20; n++)
      rd("rereset", $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15),
         $urandom_range(0, 7), $urandom_range(0, 15));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
